// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: |A - B| plus sign flag, one digit per clock.
// A negative difference is recovered from its 10^DIGITS complement in a second pass.
module bcd_serial_subtractor #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_start,
  input  logic [4*DIGITS-1:0] i_a,
  input  logic [4*DIGITS-1:0] i_b,
  output logic                o_busy,
  output logic                o_done,
  output logic [4*DIGITS-1:0] o_diff,
  output logic                o_neg,
  output logic                o_err
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SUB  = 2'd1;
  localparam logic [1:0] NEG  = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [W-1:0]     a_q, a_nxt;
  logic [W-1:0]     b_q, b_nxt;
  logic [W-1:0]     res_q, res_nxt;
  logic             borrow_q, borrow_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic             busy_nxt, done_nxt, neg_nxt, err_nxt;
  logic [W-1:0]     diff_nxt;

  logic [3:0]   minu, subt, digit;
  logic [4:0]   raw;
  logic [W-1:0] shifted;
  logic         last;
  logic         in_bad;

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_diff   <= '0;
      o_neg    <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      state    <= state_nxt;
      a_q      <= a_nxt;
      b_q      <= b_nxt;
      res_q    <= res_nxt;
      borrow_q <= borrow_nxt;
      idx_q    <= idx_nxt;
      o_busy   <= busy_nxt;
      o_done   <= done_nxt;
      o_diff   <= diff_nxt;
      o_neg    <= neg_nxt;
      o_err    <= err_nxt;
    end
  end

  // One BCD digit step; NEG pass subtracts the stored complement digit from zero
  always_comb begin
    minu    = (state == NEG) ? 4'd0 : a_q[3:0];
    subt    = (state == NEG) ? res_q[3:0] : b_q[3:0];
    raw     = {1'b0, minu} - {1'b0, subt} - {4'd0, borrow_q};
    digit   = raw[4] ? (raw[3:0] + 4'd10) : raw[3:0];
    shifted = (res_q >> 4) | (W'(digit) << (W - 4));
    last    = (idx_q == IDX_W'(DIGITS - 1));
  end

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (i_a[4*i +: 4] > 4'd9 || i_b[4*i +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt  = state;
    a_nxt      = a_q;
    b_nxt      = b_q;
    res_nxt    = res_q;
    borrow_nxt = borrow_q;
    idx_nxt    = idx_q;
    busy_nxt   = o_busy;
    done_nxt   = 1'b0;
    diff_nxt   = o_diff;
    neg_nxt    = o_neg;
    err_nxt    = o_err;

    case (state)
      IDLE: begin
        if (i_start) begin
          a_nxt      = i_a;
          b_nxt      = i_b;
          res_nxt    = '0;
          borrow_nxt = 1'b0;
          idx_nxt    = '0;
          busy_nxt   = 1'b1;
          state_nxt  = in_bad ? ERR : SUB;
        end
      end
      SUB: begin
        a_nxt      = a_q >> 4;
        b_nxt      = b_q >> 4;
        res_nxt    = shifted;
        borrow_nxt = raw[4];
        idx_nxt    = idx_q + IDX_W'(1);
        if (last) begin
          idx_nxt    = '0;
          borrow_nxt = 1'b0;
          if (!raw[4]) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            diff_nxt  = shifted;
            neg_nxt   = 1'b0;
            err_nxt   = 1'b0;
          end else begin
            state_nxt = NEG;
          end
        end
      end
      NEG: begin
        res_nxt    = shifted;
        borrow_nxt = raw[4];
        idx_nxt    = idx_q + IDX_W'(1);
        if (last) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          diff_nxt  = shifted;
          neg_nxt   = 1'b1;
          err_nxt   = 1'b0;
        end
      end
      ERR: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        diff_nxt  = '0;
        neg_nxt   = 1'b0;
        err_nxt   = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
